// File: rtl/nibble_serial_adder_controller_if.sv
// Request/result handshake bundle for the nibble-serial adder controller.
// The master side presents operands and consumes results; the slave side is the controller.
interface nibble_serial_adder_controller_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_sum, res_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_sum, res_cout
    );
endinterface

// File: rtl/nibble_serial_adder_controller.sv
// Wide adder built by time-multiplexing one external 4-bit ripple-carry adder,
// one nibble per clock, with the carry fed back through a register.
module nibble_serial_adder_controller #(
    parameter int NIBBLES = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    nibble_serial_adder_controller_if.slave         bus,
    output logic                                    busy,
    output logic [3:0]                              add_a,
    output logic [3:0]                              add_b,
    output logic                                    add_cin,
    input  logic [3:0]                              add_s,
    input  logic                                    add_cout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [W-1:0]       sum_q;
    logic [W-1:0]       sum_merged;
    logic [W-1:0]       res_sum_q;
    logic               res_cout_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The DONE exit needs res_valid and res_ready on the same edge; res_valid is high throughout DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = RUN;
            RUN:     if (idx == LAST_IDX) state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = op_a[{idx, 2'b00} +: 4];
            add_b   = op_b[{idx, 2'b00} +: 4];
            add_cin = carry_q;
        end
    end

    always_comb begin
        sum_merged = sum_q;
        sum_merged[{idx, 2'b00} +: 4] = add_s;
    end

    // Operands are latched only at acceptance, so requester-side changes during RUN are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            idx        <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_a    <= bus.req_a;
                        op_b    <= bus.req_b;
                        carry_q <= bus.req_cin;
                        sum_q   <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_merged;
                    carry_q <= add_cout;
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        res_sum_q  <= sum_merged;
                        res_cout_q <= add_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: doc/nibble_serial_adder_controller.md
Name: nibble_serial_adder_controller

Overview:
Sequencer that performs wide additions by time-multiplexing one external four_bit_ripple_carry_adder instance. It spends one clock per nibble and feeds the latched carry back into the next nibble. It presents a valid/ready request port and a valid/ready result port. It is the controller for the lab's adder datapath when operands exceed 4 bits.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  requester presents operands.
req_ready  output  1  controller can accept a request.
req_a  input  W  operand A.
req_b  input  W  operand B.
req_cin  input  1  initial carry-in.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_sum  output  W  sum.
res_cout  output  1  final carry-out.
busy  output  1  high in RUN or DONE.
add_a  output  4  nibble A driven to the external adder.
add_b  output  4  nibble B driven to the external adder.
add_cin  output  1  carry driven to the external adder.
add_s  input  4  sum returned by the external adder (combinational).
add_cout  input  1  carry returned by the external adder (combinational).

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; req_ready=1; res_valid=0; res_sum=0; res_cout=0; busy=0; internal operand, sum, carry and nibble-index registers all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, the controller latches req_a, req_b and req_cin into internal registers, clears the sum register, sets idx=0 and moves to RUN.
  - req_ready is a registered output of the state, not a combinational function of req_valid.
- RUN:
  - req_ready=0.
  - Adder drive is combinational from registers: add_a = opA[4*idx+3 : 4*idx], add_b = opB[4*idx+3 : 4*idx], add_cin = carry register.
  - Each clock edge:
    - the sum register slice [4*idx+3 : 4*idx] takes add_s;
    - the carry register takes add_cout;
    - idx increments.
  - On the edge where idx = NIBBLES-1, the controller moves to DONE and loads res_cout from add_cout.
- DONE:
  - res_valid=1; res_sum and res_cout stay stable.
  - On an edge with res_ready=1, the controller moves to IDLE and clears res_valid.
  - res_sum and res_cout hold their last values until the next result is written.
- Adder drive outside RUN: add_a=0, add_b=0, add_cin=0.
- Latency: accept edge T0. Nibble k is captured at edge T(k+1). res_valid rises after edge T(NIBBLES), i.e. NIBBLES cycles after acceptance.
- Throughput: one result per NIBBLES+2 cycles minimum (includes the DONE handshake cycle and the IDLE accept cycle).
- Arithmetic: {res_cout, res_sum} = req_a + req_b + req_cin, exact, (W+1) bits. Intermediate carries wrap only through the carry register.
- Boundary conditions:
  - req_valid while busy: ignored; operands are not sampled; no queueing.
  - Operand inputs changing during RUN: no effect, because the operands were latched at acceptance.
  - res_ready held high before res_valid: the result is still presented for at least one cycle. The DONE→IDLE transition requires res_valid=1 and res_ready=1 on the same edge.
  - Backpressure: DONE holds indefinitely while res_ready=0.
  - rst_n asserted mid-RUN or in DONE: immediate abort to the reset values; the partial result is discarded and res_valid drops asynchronously.
  - idx is sized ceil(log2(NIBBLES)) bits and never exceeds NIBBLES-1.

Test Plan:
- Basic add, NIBBLES=4: A=16'h1234, B=16'h4321, cin=0 → res_valid 4 cycles after accept; sum=16'h5555, cout=0; add_cin=0 on every RUN cycle.
- Full carry ripple: A=16'hFFFF, B=16'h0000, cin=1 → sum=16'h0000, cout=1; add_cin=1 on all 4 RUN cycles.
- Overflow from the top nibble: A=16'h8000, B=16'h8000, cin=0 → sum=16'h0000, cout=1; add_cin sequence is 0,0,0,0.
- Backpressure and ignored request: hold res_ready=0 for 3 cycles after res_valid; drive req_valid=1 with A=16'h0001 during RUN and DONE. Required response: res_valid and sum held stable; req_ready=0 throughout; the second request is accepted only in the following IDLE cycle and returns its own correct sum.
- Reset mid-operation: assert rst_n=0 at the 2nd RUN cycle of A=16'h0F0F, B=16'h0101. Required response: immediately req_ready=1, res_valid=0, res_sum=0, busy=0. A new request after reset (A=16'h0003, B=16'h0004) → sum=16'h0007, cout=0.
- Back-to-back requests with req_valid held high and res_ready=1: two results delivered, spaced exactly 6 cycles apart (NIBBLES+2).
